// File: rtl/ram8x8_pkg.sv
// Shared types and sizes for the 8x8 RAM master: address/data widths, burst length, FSM states.
package ram8x8_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 8;

  // Word-count preload for a burst: counts down to zero on the final word.
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_WAIT_S,
    RSP
  } state_t;

endpackage

// File: rtl/ram8x8_addr_seq.sv
// Modulo-8 word address and remaining-word counter; load on command accept, step once per word.
// Zero latency to outputs from the register; no backpressure of its own, the FSM gates step.
module ram8x8_addr_seq
  import ram8x8_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic              burst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] count;

  // Address wraps 7->0 naturally through the 3-bit width.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= start_addr;
      count <= burst ? LAST_CNT : '0;
    end else if (step) begin
      addr  <= addr + ADDR_W'(1);
      count <= count - ADDR_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/ram8x8_master.sv
// Single/8-word burst master for an 8x8 RAM; write 1 cycle/word, read RD_WAIT+1 cycles to rsp_valid.
// One command in flight (req_ready only in IDLE); rsp_ready low stalls in RSP with no memory access.
module ram8x8_master
  import ram8x8_pkg::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        wait_cnt;
  logic              accept;
  logic              seq_step;
  logic              seq_last;
  logic              sample;
  logic [ADDR_W-1:0] seq_addr;

  ram8x8_addr_seq u_addr_seq (
    .clock      (clock),
    .clear      (clear),
    .load       (accept),
    .burst      (req_burst),
    .start_addr (req_addr),
    .step       (seq_step),
    .addr       (seq_addr),
    .last       (seq_last)
  );

  // Ready is gated by clear so it reads 0 while reset is held.
  assign req_ready   = (state == IDLE) && clear;
  assign accept      = req_valid && req_ready;
  assign busy        = (state != IDLE);
  assign mem_rw      = (state == WRITE);
  assign mem_address = seq_addr;
  assign mem_wdata   = data_q;
  assign rsp_valid   = (state == RSP);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seq_step  = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE:      if (accept) state_nxt = req_write ? WRITE : RD_ADDR;
      WRITE: begin
        if (seq_last) state_nxt = IDLE;
        else          seq_step  = 1'b1;
      end
      RD_ADDR:   state_nxt = RD_WAIT_S;
      RD_WAIT_S: begin
        if (wait_cnt == WAIT_LAST) begin
          sample    = 1'b1;
          state_nxt = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (seq_last) begin
            state_nxt = IDLE;
          end else begin
            seq_step  = 1'b1;
            state_nxt = RD_ADDR;
          end
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // wait_cnt counts RD_WAIT_S cycles; it is primed to 1 on the RD_ADDR cycle.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      data_q   <= '0;
      wait_cnt <= '0;
      rsp_data <= '0;
      rsp_addr <= '0;
      rsp_last <= 1'b0;
    end else begin
      if (accept) data_q <= req_data;
      if (state == RD_ADDR)        wait_cnt <= 2'd1;
      else if (state == RD_WAIT_S) wait_cnt <= wait_cnt + 2'd1;
      if (sample) begin
        rsp_data <= mem_rdata;
        rsp_addr <= seq_addr;
        rsp_last <= seq_last;
      end
    end
  end

endmodule

// File: tb/tb_ram8x8_master.sv
// Directed bench: ram8x8_master (RD_WAIT=1 and RD_WAIT=3) each paired with an 8x8 memory model.
module tb_ram8x8_master;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, req_burst = 1'b0, rsp_ready = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, rsp_valid, rsp_last, mem_rw, busy;
  logic [7:0] rsp_data, mem_wdata, mem_rdata;
  logic [2:0] rsp_addr, mem_address;

  logic       d3_req_valid = 1'b0, d3_req_write = 1'b0, d3_rsp_ready = 1'b0;
  logic [2:0] d3_req_addr = '0;
  logic [7:0] d3_req_data = '0;
  logic       d3_req_ready, d3_rsp_valid, d3_rsp_last, d3_mem_rw, d3_busy;
  logic [7:0] d3_rsp_data, d3_mem_wdata, d3_mem_rdata;
  logic [2:0] d3_rsp_addr, d3_mem_address;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, last_hs_cyc = 0, rsp_seen = 0;
  logic [2:0] wr_log_addr [$];
  int         wr_log_cyc [$];

  logic [7:0] got_data [8];
  logic [2:0] got_addr [8];
  logic       got_last [8];
  int         got_n;
  bit         stall_ok;

  logic [7:0] mem  [8];
  logic [7:0] mem3 [8];

  always #5 clock = ~clock;

  ram8x8_master #(.RD_WAIT(1)) u_dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_burst(req_burst), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last),
    .mem_address(mem_address), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  ram8x8_master #(.RD_WAIT(3)) u_dut3 (
    .clock(clock), .clear(clear),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(d3_req_write),
    .req_burst(1'b0), .req_addr(d3_req_addr), .req_data(d3_req_data),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_data(d3_rsp_data),
    .rsp_addr(d3_rsp_addr), .rsp_last(d3_rsp_last),
    .mem_address(d3_mem_address), .mem_rw(d3_mem_rw), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata), .busy(d3_busy)
  );

  always @(posedge clock) if (mem_rw) mem[mem_address] <= mem_wdata;
  assign mem_rdata = mem[mem_address];
  always @(posedge clock) if (d3_mem_rw) mem3[d3_mem_address] <= d3_mem_wdata;
  assign d3_mem_rdata = mem3[d3_mem_address];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_rw) begin
      wr_log_addr.push_back(mem_address);
      wr_log_cyc.push_back(cyc);
    end
    if (req_valid && req_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc = cyc;
    end
    if (rsp_valid && rsp_ready && rsp_last) last_hs_cyc = cyc;
    if (rsp_valid) rsp_seen = rsp_seen + 1;
  end

  task automatic send(input logic w, input logic b, input logic [2:0] a,
                      input logic [7:0] d, output bit ok);
    ok = 1'b0;
    req_write = w; req_burst = b; req_addr = a; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
  endtask

  // Drains up to n responses; optionally withholds rsp_ready for stall_cyc cycles on word stall_idx.
  task automatic collect(input int n, input int stall_idx, input int stall_cyc);
    logic [7:0] sd;
    logic [2:0] sa;
    logic       sl;
    got_n = 0;
    stall_ok = 1'b1;
    for (int t = 0; t < 1000 && got_n < n; t++) begin
      if (rsp_valid) begin
        if (got_n == stall_idx) begin
          rsp_ready = 1'b0;
          sd = rsp_data; sa = rsp_addr; sl = rsp_last;
          for (int k = 0; k < stall_cyc; k++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_data !== sd || rsp_addr !== sa || rsp_last !== sl || mem_rw)
              stall_ok = 1'b0;
          end
        end
        got_data[got_n] = rsp_data;
        got_addr[got_n] = rsp_addr;
        got_last[got_n] = rsp_last;
        got_n = got_n + 1;
        rsp_ready = 1'b1;
      end else begin
        rsp_ready = 1'b0;
      end
      @(negedge clock);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, mem_address, mem_rw, mem_wdata, busy} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b d=%h a=%0d last=%b ma=%0d rw=%b wd=%h busy=%b want all 0",
               req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, mem_address, mem_rw, mem_wdata, busy);
    end
    clear = 1'b1;
    #1;
    total++;
    if ({req_ready, busy, d3_req_ready, d3_busy} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b busy=%b d3rdy=%b d3busy=%b want 1 0 1 0",
               req_ready, busy, d3_req_ready, d3_busy);
    end
    @(negedge clock);
  endtask

  task automatic test_single_write_read();
    bit ok;
    int base, n;
    base = wr_log_addr.size();
    send(1'b1, 1'b0, 3'd3, 8'hA5, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL sw_accept: got no accept want accept"); end
    total++;
    if ({mem_rw, mem_address, mem_wdata, busy, req_ready} !== {1'b1, 3'd3, 8'hA5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sw_pulse: got rw=%b a=%0d d=%h busy=%b rdy=%b want 1 3 a5 1 0",
               mem_rw, mem_address, mem_wdata, busy, req_ready);
    end
    @(negedge clock);
    total++;
    if ({mem_rw, req_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL sw_done: got rw=%b rdy=%b busy=%b want 0 1 0", mem_rw, req_ready, busy);
    end
    total++;
    if (wr_log_addr.size() - base !== 1) begin
      bad++;
      $display("FAIL sw_pulses: got %0d want 1", wr_log_addr.size() - base);
    end
    send(1'b0, 1'b0, 3'd3, 8'h00, ok);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
    total++;
    if (n !== 2) begin bad++; $display("FAIL sr_latency: got %0d want 2", n); end
    total++;
    if ({rsp_data, rsp_addr, rsp_last} !== {8'hA5, 3'd3, 1'b1}) begin
      bad++;
      $display("FAIL sr_word: got d=%h a=%0d last=%b want a5 3 1", rsp_data, rsp_addr, rsp_last);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready, wr_log_addr.size() - base} !== {1'b0, 1'b1, 32'd1}) begin
      bad++;
      $display("FAIL sr_done: got vld=%b rdy=%b pulses=%0d want 0 1 1", rsp_valid, req_ready,
               wr_log_addr.size() - base);
    end
  endtask

  task automatic test_burst_write();
    bit ok;
    int base;
    base = wr_log_addr.size();
    send(1'b1, 1'b1, 3'd5, 8'h3C, ok);
    wait_idle();
    total++;
    if (wr_log_addr.size() - base !== 8) begin
      bad++;
      $display("FAIL bw_pulses: got %0d want 8", wr_log_addr.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (wr_log_addr[base + k] !== 3'(5 + k)) begin
          bad++;
          $display("FAIL bw_addr%0d: got %0d want %0d", k, wr_log_addr[base + k], 3'(5 + k));
        end
      end
      total++;
      if (wr_log_cyc[base + 7] - wr_log_cyc[base] !== 7) begin
        bad++;
        $display("FAIL bw_consecutive: got span %0d want 7", wr_log_cyc[base + 7] - wr_log_cyc[base]);
      end
    end
  endtask

  task automatic test_burst_read();
    bit ok;
    send(1'b0, 1'b1, 3'd0, 8'h00, ok);
    collect(8, 8, 0);
    total++;
    if (got_n !== 8) begin bad++; $display("FAIL br_count: got %0d want 8", got_n); end
    for (int k = 0; k < got_n; k++) begin
      total++;
      if ({got_addr[k], got_data[k], got_last[k]} !== {3'(k), 8'h3C, k == 7}) begin
        bad++;
        $display("FAIL br_word%0d: got a=%0d d=%h last=%b want %0d 3c %b",
                 k, got_addr[k], got_data[k], got_last[k], k, k == 7);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int base;
    logic [2:0] ea;
    send(1'b1, 1'b0, 3'd0, 8'h11, ok);
    wait_idle();
    base = wr_log_addr.size();
    send(1'b0, 1'b1, 3'd6, 8'h00, ok);
    collect(8, 2, 5);
    total++;
    if (!stall_ok) begin bad++; $display("FAIL stall_hold: got word changed or dropped want held"); end
    total++;
    if ({got_n, wr_log_addr.size() - base} !== {32'd8, 32'd0}) begin
      bad++;
      $display("FAIL stall_count: got words=%0d pulses=%0d want 8 0", got_n, wr_log_addr.size() - base);
    end
    for (int k = 0; k < got_n; k++) begin
      ea = 3'(6 + k);
      total++;
      if ({got_addr[k], got_data[k], got_last[k]} !== {ea, (ea == 3'd0) ? 8'h11 : 8'h3C, k == 7}) begin
        bad++;
        $display("FAIL stall_word%0d: got a=%0d d=%h last=%b want %0d", k, got_addr[k], got_data[k],
                 got_last[k], ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = acc_cnt;
    req_write = 1'b0; req_burst = 1'b1; req_addr = 3'd2; req_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge clock);
    collect(8, 8, 0);
    total++;
    if ({got_n, acc_cnt - a0} !== {32'd8, 32'd1}) begin
      bad++;
      $display("FAIL b2b_held: got words=%0d accepts=%0d want 8 1", got_n, acc_cnt - a0);
    end
    total++;
    if ({got_addr[7], got_last[7]} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL b2b_last: got a=%0d last=%b want 1 1", got_addr[7], got_last[7]);
    end
    for (int i = 0; i < 10 && acc_cnt - a0 < 2; i++) @(negedge clock);
    req_valid = 1'b0;
    total++;
    if ({acc_cnt - a0, acc_cyc - last_hs_cyc} !== {32'd2, 32'd1}) begin
      bad++;
      $display("FAIL b2b_second: got accepts=%0d gap=%0d want 2 1", acc_cnt - a0, acc_cyc - last_hs_cyc);
    end
    collect(8, 8, 0);
    total++;
    if ({got_n, got_addr[0]} !== {32'd8, 3'd2}) begin
      bad++;
      $display("FAIL b2b_drain: got words=%0d a0=%0d want 8 2", got_n, got_addr[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int base, r0, n;
    base = wr_log_addr.size();
    send(1'b1, 1'b1, 3'd0, 8'h77, ok);
    for (int i = 0; i < 20 && wr_log_addr.size() - base < 3; i++) @(negedge clock);
    clear = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, mem_address, mem_rw, mem_wdata, busy} !== 27'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got rw=%b ma=%0d wd=%h busy=%b vld=%b want all 0",
               mem_rw, mem_address, mem_wdata, busy, rsp_valid);
    end
    repeat (2) @(negedge clock);
    clear = 1'b1;
    r0 = rsp_seen;
    repeat (12) @(negedge clock);
    total++;
    if ({wr_log_addr.size() - base, rsp_seen - r0, busy} !== {32'd3, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_quiet: got pulses=%0d rsp=%0d busy=%b want 3 0 0",
               wr_log_addr.size() - base, rsp_seen - r0, busy);
    end
    send(1'b0, 1'b0, 3'd0, 8'h00, ok);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
    total++;
    if ({n, rsp_data, rsp_addr, rsp_last} !== {32'd2, 8'h77, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_read: got lat=%0d d=%h a=%0d last=%b want 2 77 0 1", n, rsp_data, rsp_addr, rsp_last);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_rd_wait3();
    int n;
    d3_req_write = 1'b1; d3_req_addr = 3'd1; d3_req_data = 8'h5A; d3_req_valid = 1'b1;
    for (int i = 0; i < 20 && !d3_req_ready; i++) @(negedge clock);
    @(negedge clock);
    d3_req_valid = 1'b0;
    for (int i = 0; i < 20 && d3_busy; i++) @(negedge clock);
    d3_req_write = 1'b0; d3_req_valid = 1'b1;
    for (int i = 0; i < 20 && !d3_req_ready; i++) @(negedge clock);
    @(negedge clock);
    d3_req_valid = 1'b0;
    n = 0;
    while (!d3_rsp_valid && n < 20) begin @(negedge clock); n++; end
    total++;
    if (n !== 4) begin bad++; $display("FAIL rw3_latency: got %0d want 4", n); end
    total++;
    if ({d3_rsp_data, d3_rsp_addr, d3_rsp_last} !== {8'h5A, 3'd1, 1'b1}) begin
      bad++;
      $display("FAIL rw3_word: got d=%h a=%0d last=%b want 5a 1 1", d3_rsp_data, d3_rsp_addr, d3_rsp_last);
    end
    d3_rsp_ready = 1'b1;
    @(negedge clock);
    d3_rsp_ready = 1'b0;
    total++;
    if ({d3_rsp_valid, d3_req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rw3_done: got vld=%b rdy=%b want 0 1", d3_rsp_valid, d3_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_burst_write();
    test_burst_read();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
    test_rd_wait3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule

// File: doc/ram8x8_master.md
RAM8X8_MASTER -- requirements
Module: ram8x8_master

Interface
REQ-001 Parameter: RD_WAIT, default 1, cycles from mem_address stable to mem_rdata sample; legal 1..3.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 clear  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  command present.
REQ-005 req_ready  out  1  command accepted when req_valid&req_ready at an edge.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_burst  in  1  1=8-word operation, 0=single word.
REQ-008 req_addr  in  3  start address.
REQ-009 req_data  in  8  write data; for burst write, the fill value for all 8 words.
REQ-010 rsp_valid  out  1  read word available.
REQ-011 rsp_ready  in  1  consumer takes word when rsp_valid&rsp_ready at an edge.
REQ-012 rsp_data  out  8  read word.
REQ-013 rsp_addr  out  3  address rsp_data came from.
REQ-014 rsp_last  out  1  marks the final word of a read (always 1 for single read).
REQ-015 mem_address  out  3  memory word address.
REQ-016 mem_rw  out  1  memory write enable, active-high.
REQ-017 mem_wdata  out  8  memory write data, bit 7 = first data bit.
REQ-018 mem_rdata  in  8  memory read data, bit 7 = first data bit.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, WRITE, RD_ADDR, RD_WAIT_S, RSP.
REQ-021 req_ready SHALL be 1 only in IDLE; one command in flight.
REQ-022 On accept: latch req_addr into addr register, req_data into data register, set word count to 0 (single) or 7 (burst); go to WRITE if req_write, else RD_ADDR.
REQ-023 WRITE: mem_rw=1 for exactly one cycle per word, mem_address/mem_wdata stable that cycle; burst increments address modulo 8 (7->0) each cycle, 8 consecutive write cycles; then IDLE.
REQ-024 mem_rw SHALL be 0 in every state other than WRITE.
REQ-025 RD_ADDR drives mem_address=addr; RD_WAIT_S holds it for RD_WAIT cycles total from RD_ADDR, then samples mem_rdata into rsp_data, addr into rsp_addr, and enters RSP.
REQ-026 RSP: rsp_valid=1, rsp_data/rsp_addr/rsp_last held stable until handshake; rsp_last=1 when word count is 0.
REQ-027 On RSP handshake: count 0 -> IDLE; else decrement count, address+1 modulo 8, -> RD_ADDR.
REQ-028 Burst read from start a returns addresses a, a+1, ..., a+7 mod 8, eight words, in order.
REQ-029 rsp_ready low indefinitely stalls in RSP with no memory access and no data change.
REQ-030 Single write latency: accept edge + 1 cycle mem_rw pulse; req_ready returns the following cycle.
REQ-031 Single read latency: rsp_valid asserted RD_WAIT+1 cycles after accept edge.
REQ-032 req_valid while busy is ignored, no state change; requester holds it.

Reset
REQ-033 clear low forces, asynchronously: state IDLE, req_ready 0 during reset then 1 after, rsp_valid 0, rsp_data 0, rsp_addr 0, rsp_last 0, mem_address 0, mem_rw 0, mem_wdata 0, busy 0.
REQ-034 Reset mid-burst abandons the operation; no further mem_rw pulses or responses after release.

Structure
REQ-035 Shared package: state encoding typedef, ADDR_W=3, DATA_W=8, BURST_LEN=8.
REQ-036 One sub-module: ram8x8_addr_seq (modulo-8 address and word counter) instantiated once.

Verification (bench pairs the block with the 8x8 memory)
REQ-037 Single write 0xA5 to addr 3, then single read addr 3 -> one mem_rw pulse at addr 3; rsp_data=0xA5, rsp_addr=3, rsp_last=1.
REQ-038 Burst write fill 0x3C start 5 -> 8 mem_rw pulses, addresses 5,6,7,0,1,2,3,4; burst read start 0 returns 0x3C x8, rsp_last only on 8th.
REQ-039 Burst read start 6 with rsp_ready low 5 cycles on word 2 -> rsp_addr 6,7,0,...,5, word 2 data/addr held stable through stall.
REQ-040 req_valid held during burst -> second command accepted only on cycle after final handshake.
REQ-041 clear pulsed low after 3rd burst-write pulse -> all outputs at reset values immediately, mem_rw never reasserts, next read of addr 0 completes normally.
REQ-042 RD_WAIT=3 single read addr 1 -> rsp_valid exactly 4 cycles after accept.
